// File: rtl/tri_driver.sv
// tri_driver: host-side driver for the triangle rasterizer.
// Takes one triangle descriptor over a valid/ready port and sends it to the
// rasterizer as an nt strobe plus three vertices. It then collects the
// returned point stream into an 8x8 occupancy bitmap and a saturating
// point count, and pulses done when the rasterizer goes idle.
// Optional feature: define TRI_DRV_WD_EN to enable a WAIT/COLLECT watchdog
// with the sticky err flag.
module tri_driver #(
    parameter int WD_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_vtx,
    output logic        nt,
    output logic [2:0]  xi,
    output logic [2:0]  yi,
    input  logic        busy,
    input  logic        po,
    input  logic [2:0]  xo,
    input  logic [2:0]  yo,
    output logic [63:0] bitmap,
    output logic [6:0]  pix_cnt,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, S2, S3, WAIT, COLLECT, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] vtx_q;      // {x2,y2,x3,y3}; v1 goes straight out on accept
    logic        accept;
    logic        capture;
    logic        done_nxt;
    logic        wd_fire;

    // Point counter increment that sticks at the 7-bit maximum
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == 7'h7f) ? v : v + 7'd1;
    endfunction

    assign cmd_ready = (state == IDLE) && !busy;
    assign accept    = cmd_valid && cmd_ready;

`ifdef TRI_DRV_WD_EN
    logic [7:0] wd_cnt;

    assign wd_fire = ((state == WAIT) || (state == COLLECT)) &&
                     (({1'b0, wd_cnt} + 9'd1) == 9'(WD_LIMIT));

    // Watchdog counter: cleared as the FSM enters WAIT, runs through WAIT/COLLECT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= 8'd0;
        else if (state == S3)
            wd_cnt <= 8'd0;
        else if ((state == WAIT) || (state == COLLECT))
            wd_cnt <= wd_cnt + 8'd1;
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (wd_fire)
            err <= 1'b1;
    end
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic, point capture enable and done request
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = WAIT;
            WAIT: begin
                capture = po;
                if (wd_fire) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (busy) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                capture = po;
                if (wd_fire) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (!busy) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vertex holding register for v2/v3; pure data, needs no reset
    always_ff @(posedge clk) begin
        if (accept)
            vtx_q <= cmd_vtx[11:0];
    end

    // Registered rasterizer drive, bitmap/count accumulation and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nt      <= 1'b0;
            xi      <= 3'd0;
            yi      <= 3'd0;
            done    <= 1'b0;
            bitmap  <= 64'd0;
            pix_cnt <= 7'd0;
        end else begin
            done <= done_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        nt      <= 1'b1;
                        xi      <= cmd_vtx[17:15];
                        yi      <= cmd_vtx[14:12];
                        bitmap  <= 64'd0;
                        pix_cnt <= 7'd0;
                    end
                end
                S2: begin
                    nt <= 1'b0;
                    xi <= vtx_q[11:9];
                    yi <= vtx_q[8:6];
                end
                S3: begin
                    xi <= vtx_q[5:3];
                    yi <= vtx_q[2:0];
                end
                default: ;
            endcase
            if (capture) begin
                bitmap[{yo, xo}] <= 1'b1;
                pix_cnt          <= sat_inc(pix_cnt);
            end
        end
    end

endmodule

// File: tb/tb_tri_driver.sv
// tb_tri_driver: directed bench for tri_driver with a scripted rasterizer.
// The watchdog section is built when TRI_DRV_WD_EN is defined; otherwise an
// unbounded-wait section runs instead.
module tb_tri_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [17:0] cmd_vtx = 18'd0;
    logic        nt;
    logic [2:0]  xi, yi;
    logic        busy = 1'b0;
    logic        po = 1'b0;
    logic [2:0]  xo = 3'd0, yo = 3'd0;
    logic [63:0] bitmap;
    logic [6:0]  pix_cnt;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [17:0] V_BASIC   = {3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd4};
    localparam logic [17:0] V_OTHER   = {3'd2, 3'd2, 3'd6, 3'd2, 3'd2, 3'd6};
    localparam logic [63:0] MAP_BASIC = 64'h0000_0002_060E_1E00;

    int px [10] = '{1, 2, 3, 4, 1, 2, 3, 1, 2, 1};
    int py [10] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 4};

    always #5 clk = ~clk;

    tri_driver #(.WD_LIMIT(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_vtx   (cmd_vtx),
        .nt        (nt),
        .xi        (xi),
        .yi        (yi),
        .busy      (busy),
        .po        (po),
        .xo        (xo),
        .yo        (yo),
        .bitmap    (bitmap),
        .pix_cnt   (pix_cnt),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tri(input logic [17:0] v);
        cmd_vtx   = v;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic emit(input int x, input int y);
        busy = 1'b1;
        po   = 1'b1;
        xo   = 3'(x);
        yo   = 3'(y);
        tick();
        po   = 1'b0;
    endtask

    task automatic end_tri();
        busy = 1'b0;
        po   = 1'b0;
        tick();
    endtask

    task automatic run_basic(input string tag);
        cmd_vtx   = V_BASIC;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check({tag, "_nt_v1"}, 64'(nt), 64'd1);
        check({tag, "_xy_v1"}, 64'({xi, yi}), 64'o11);
        tick();
        check({tag, "_nt_v2"}, 64'(nt), 64'd0);
        check({tag, "_xy_v2"}, 64'({xi, yi}), 64'o41);
        tick();
        check({tag, "_xy_v3"}, 64'({xi, yi}), 64'o14);
        busy = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) emit(px[i], py[i]);
        check({tag, "_done_early"}, 64'(done), 64'd0);
        end_tri();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_pix_cnt"}, 64'(pix_cnt), 64'd10);
        check({tag, "_bitmap"}, bitmap, MAP_BASIC);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_xy_hold"}, 64'({xi, yi}), 64'o14);
        check({tag, "_bitmap_hold"}, bitmap, MAP_BASIC);
    endtask

    initial begin
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_nt", 64'(nt), 64'd0);
        check("rst_xy", 64'({xi, yi}), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_pix", 64'(pix_cnt), 64'd0);
        check("rst_bitmap", bitmap, 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        tick();

        run_basic("basic");

        // Back-pressure: command waits while the rasterizer is busy
        busy      = 1'b1;
        cmd_vtx   = V_OTHER;
        cmd_valid = 1'b1;
        #1;
        check("bp_ready_low", 64'(cmd_ready), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= nt;
        end
        check("bp_no_nt", 64'(seen), 64'd0);
        busy = 1'b0;
        #1;
        check("bp_ready_high", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        check("bp_accept_nt", 64'(nt), 64'd1);
        check("bp_xy_v1", 64'({xi, yi}), 64'o22);
        check("bp_pix_clr", 64'(pix_cnt), 64'd0);
        check("bp_bitmap_clr", bitmap, 64'd0);
        tick();
        tick();
        busy = 1'b1;
        tick();
        end_tri();
        check("bp_done", 64'(done), 64'd1);
        tick();

        // Duplicates and saturation
        start_tri(V_BASIC);
        for (int i = 0; i < 130; i++) emit(2, 2);
        end_tri();
        check("dup_done", 64'(done), 64'd1);
        check("dup_bitmap", bitmap, 64'h0000_0000_0004_0000);
        check("dup_pix_sat", 64'(pix_cnt), 64'd127);
        tick();

        // Last point arrives on the same cycle busy falls
        start_tri(V_BASIC);
        emit(1, 1);
        check("last_done_early", 64'(done), 64'd0);
        busy = 1'b0;
        po   = 1'b1;
        xo   = 3'd5;
        yo   = 3'd5;
        tick();
        po   = 1'b0;
        check("last_done", 64'(done), 64'd1);
        check("last_bitmap", bitmap, 64'h0000_2000_0000_0200);
        check("last_pix", 64'(pix_cnt), 64'd2);
        tick();
        check("last_done_pulse", 64'(done), 64'd0);

        // Reset in the middle of COLLECT
        start_tri(V_OTHER);
        emit(1, 1);
        emit(2, 1);
        emit(3, 1);
        busy  = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_nt", 64'(nt), 64'd0);
        check("mid_rst_xy", 64'({xi, yi}), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_pix", 64'(pix_cnt), 64'd0);
        check("mid_rst_bitmap", bitmap, 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        run_basic("post_rst");

`ifdef TRI_DRV_WD_EN
        // Watchdog with WD_LIMIT=20 and busy stuck high
        start_tri(V_BASIC);
        busy = 1'b1;
        seen = 1'b0;
        for (int k = 1; k < 20; k++) begin
            tick();
            seen |= done;
        end
        check("wd_done_early", 64'(seen), 64'd0);
        check("wd_err_early", 64'(err), 64'd0);
        tick();
        check("wd_done", 64'(done), 64'd1);
        check("wd_err", 64'(err), 64'd1);
        tick();
        check("wd_done_pulse", 64'(done), 64'd0);
        check("wd_err_sticky", 64'(err), 64'd1);
        check("wd_ready_gated", 64'(cmd_ready), 64'd0);
        busy = 1'b0;
        #1;
        check("wd_ready", 64'(cmd_ready), 64'd1);
        tick();
        check("wd_err_held", 64'(err), 64'd1);
`else
        // Without the watchdog a stuck busy just waits
        start_tri(V_BASIC);
        busy = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            tick();
            seen |= done;
        end
        check("nowd_no_done", 64'(seen), 64'd0);
        end_tri();
        check("nowd_done", 64'(done), 64'd1);
        check("nowd_err", 64'(err), 64'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
